// File: rtl/decoder_38_seq.sv
// decoder_38_seq: registered 3-to-8 decoder for the receiving end of an
// 8-3 priority encoder link (Y, GS, EO), with a one-deep valid/ready stage.
// It keeps a sticky mask of decoded lines, a saturating count of
// "enabled, no request" codes, and a sticky flag for illegal GS/EO pairs.
//
// Optional build macro: DEC38_ACTIVE_LOW_EN
//   When defined, D is driven inverted in the 74x138 style: idle/reset
//   value 8'hFF, and a request drives bit Y low. seen stays active-high.
module decoder_38_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       Y,
    input  logic             GS,
    input  logic             EO,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       D,
    output logic [7:0]       seen,
    output logic [CNT_W-1:0] empty_cnt,
    output logic             err,
    input  logic             clr
);

`ifdef DEC38_ACTIVE_LOW_EN
    localparam logic [7:0] D_RST = 8'hFF;
`else
    localparam logic [7:0] D_RST = 8'h00;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Code classes carried on the GS/EO pair.
    typedef enum logic [1:0] {
        CLS_DISABLED = 2'b00,
        CLS_EMPTY    = 2'b01,
        CLS_REQUEST  = 2'b10,
        CLS_ILLEGAL  = 2'b11
    } code_cls_e;

    // One-hot line for an encoded index (active-high).
    function automatic logic [7:0] onehot_of(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

    // Map an active-high decoded vector onto the D pin polarity.
    function automatic logic [7:0] pin_polarity(input logic [7:0] vec);
`ifdef DEC38_ACTIVE_LOW_EN
        return ~vec;
`else
        return vec;
`endif
    endfunction

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (val == CNT_MAX) begin
            return val;
        end else begin
            return val + CNT_ONE;
        end
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [7:0]       d_q, d_d;
    logic [7:0]       seen_q, seen_d;
    logic [CNT_W-1:0] empty_cnt_q, empty_cnt_d;
    logic             err_q, err_d;

    logic             in_ready_s;
    logic             accept_s;
    code_cls_e        cls_s;
    logic [7:0]       dec_s;
    logic             is_empty_s;
    logic             is_illegal_s;
    logic [7:0]       seen_base_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic             err_base_s;

    // Handshake: the single output slot is free when empty or draining now.
    always_comb begin
        in_ready_s = (!out_valid_q) || out_ready;
        accept_s   = in_valid && in_ready_s;
    end

    // Classify the incoming code and build its active-high decoded vector.
    always_comb begin
        cls_s        = code_cls_e'({GS, EO});
        dec_s        = 8'h00;
        is_empty_s   = 1'b0;
        is_illegal_s = 1'b0;
        case (cls_s)
            CLS_REQUEST:  dec_s        = onehot_of(Y);
            CLS_EMPTY:    is_empty_s   = 1'b1;
            CLS_DISABLED: dec_s        = 8'h00;
            CLS_ILLEGAL:  is_illegal_s = 1'b1;
            default:      dec_s        = 8'h00;
        endcase
    end

    // Next-state for the output slot and the sticky status; a clear in the
    // same cycle as an accept leaves only that code's contribution.
    always_comb begin
        out_valid_d = out_valid_q;
        d_d         = d_q;
        seen_d      = seen_q;
        empty_cnt_d = empty_cnt_q;
        err_d       = err_q;

        if (clr) begin
            seen_base_s = 8'h00;
            cnt_base_s  = CNT_ZERO;
            err_base_s  = 1'b0;
        end else begin
            seen_base_s = seen_q;
            cnt_base_s  = empty_cnt_q;
            err_base_s  = err_q;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            d_d         = pin_polarity(dec_s);
            seen_d      = seen_base_s | dec_s;
            if (is_empty_s) begin
                empty_cnt_d = sat_inc(cnt_base_s);
            end else begin
                empty_cnt_d = cnt_base_s;
            end
            err_d = err_base_s | is_illegal_s;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            seen_d      = seen_base_s;
            empty_cnt_d = cnt_base_s;
            err_d       = err_base_s;
        end
    end

    // State registers with synchronous reset; reset drops any held code.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            d_q         <= D_RST;
            seen_q      <= 8'h00;
            empty_cnt_q <= CNT_ZERO;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            d_q         <= d_d;
            seen_q      <= seen_d;
            empty_cnt_q <= empty_cnt_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign D         = d_q;
    assign seen      = seen_q;
    assign empty_cnt = empty_cnt_q;
    assign err       = err_q;

endmodule

// File: tb/tb_decoder_38_seq.sv
// Scoreboard bench for decoder_38_seq: the driver pushes the expected D of
// every accepted code into a queue, and an independent monitor pops and
// compares whenever the DUT presents a code. Sticky status is tracked by a
// small reference model built from the decode rules.
module tb_decoder_38_seq;

    localparam int CW = 2;

`ifdef DEC38_ACTIVE_LOW_EN
    localparam logic [7:0] D_RST = 8'hFF;
`else
    localparam logic [7:0] D_RST = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    Y = 3'd0;
    logic          GS = 1'b0;
    logic          EO = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [7:0]    D;
    logic [7:0]    seen;
    logic [CW-1:0] empty_cnt;
    logic          err;
    logic          clr = 1'b0;

    decoder_38_seq #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Y(Y), .GS(GS), .EO(EO), .out_valid(out_valid), .out_ready(out_ready),
        .D(D), .seen(seen), .empty_cnt(empty_cnt), .err(err), .clr(clr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Scoreboard of expected D values (at most one outstanding).
    logic [7:0] exp_q[$];

    // Reference model of sticky status.
    logic [7:0] m_seen = 8'h00;
    int         m_cnt  = 0;
    logic       m_err  = 1'b0;

    // What was presented for the edge that is coming.
    logic       p_rst = 1'b1;
    logic       p_acc = 1'b0;
    logic       p_clr = 1'b0;
    logic [2:0] p_y   = 3'd0;
    logic       p_gs  = 1'b0;
    logic       p_eo  = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] pin_of(input logic [7:0] v);
`ifdef DEC38_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    // Apply the model effects of the edge just passed, then present new inputs.
    task automatic step(input logic r, input logic iv, input logic [2:0] y,
                        input logic gs, input logic eo, input logic ordy, input logic c);
        logic [7:0] v;
        int         base;
        @(posedge clk);
        #1;
        if (p_rst) begin
            exp_q.delete();
            m_seen = 8'h00;
            m_cnt  = 0;
            m_err  = 1'b0;
        end else if (p_acc) begin
            v = (p_gs && !p_eo) ? (8'h01 << p_y) : 8'h00;
            exp_q.push_back(pin_of(v));
            m_seen = p_clr ? v : (m_seen | v);
            base   = p_clr ? 0 : m_cnt;
            if (!p_gs && p_eo && base < (1 << CW) - 1) base = base + 1;
            m_cnt  = base;
            m_err  = p_clr ? (p_gs && p_eo) : (m_err || (p_gs && p_eo));
        end else if (p_clr) begin
            m_seen = 8'h00;
            m_cnt  = 0;
            m_err  = 1'b0;
        end
        rst = r; in_valid = iv; Y = y; GS = gs; EO = eo; out_ready = ordy; clr = c;
        p_rst = r;
        p_clr = c;
        p_y   = y;
        p_gs  = gs;
        p_eo  = eo;
        p_acc = !r && iv && ((exp_q.size() == 0) || ordy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    // Monitor: pop and compare on every presented/drained code, check status.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (exp_q.size() == 0) || out_ready});
            check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("D", {24'd0, D}, {24'd0, exp_q[0]});
                if (out_ready) void'(exp_q.pop_front());
            end
            check("seen", {24'd0, seen}, {24'd0, m_seen});
            check("empty_cnt", {{(32-CW){1'b0}}, empty_cnt}, m_cnt);
            check("err", {31'd0, err}, {31'd0, m_err});
        end
    end

    initial begin
        // Reset then idle.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(1);
        @(negedge clk);
        #1;
        check("D_reset", {24'd0, D}, {24'd0, D_RST});
        idle(1);

        // Streaming requests with out_ready=1.
        step(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Backpressure with a competing code held on the inputs.
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Class coverage then clear.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0);
        idle(1);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Saturation then clear coincident with an accept.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        idle(2);

        // Reset while a code is held under backpressure.
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        @(negedge clk);
        #1;
        check("D_after_rst", {24'd0, D}, {24'd0, D_RST});
        idle(1);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
